// File: rtl/fc_argmax_reader.sv
// Argmax reader for the fully connected output vector.
// Captures all logits on a handshake, then scans one element per clock and returns the winning index and score.
module fc_argmax_reader #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned OUTPUT_NODES = 10,
  parameter int unsigned IDX_WIDTH    = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [IDX_WIDTH-1:0]               out_class,
  output logic [DATA_WIDTH-1:0]              out_score,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy
);

  localparam int unsigned LAST = OUTPUT_NODES - 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LAST);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                                     state_q, state_nxt;
  logic [OUTPUT_NODES-1:0][DATA_WIDTH-1:0]    vec_q, vec_nxt;
  logic [DATA_WIDTH-1:0]                      max_q, max_nxt, elem;
  logic [IDX_WIDTH-1:0]                       idx_q, idx_nxt, cnt_q, cnt_nxt;
  logic [IDX_WIDTH-1:0]                       class_nxt;
  logic [DATA_WIDTH-1:0]                      score_nxt;

  // Next-state and datapath: one shared signed comparator against element[cnt]
  always_comb begin
    state_nxt = state_q;
    vec_nxt   = vec_q;
    max_nxt   = max_q;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    class_nxt = out_class;
    score_nxt = out_score;
    elem      = vec_q[cnt_q];
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_nxt = in_data;
          max_nxt = in_data[DATA_WIDTH-1:0];
          idx_nxt = '0;
          if (LAST == 0) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
            class_nxt = '0;
            score_nxt = in_data[DATA_WIDTH-1:0];
          end else begin
            state_nxt = SCAN;
            cnt_nxt   = IDX_WIDTH'(1);
          end
        end
      end
      SCAN: begin
        // Strictly greater only, so ties keep the lower index
        if ($signed(elem) > $signed(max_q)) begin
          max_nxt = elem;
          idx_nxt = cnt_q;
        end
        cnt_nxt = cnt_q + IDX_WIDTH'(1);
        if (cnt_q == LAST_IDX) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          class_nxt = idx_nxt;
          score_nxt = max_nxt;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      out_class <= '0;
      out_score <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      vec_q     <= vec_nxt;
      max_q     <= max_nxt;
      idx_q     <= idx_nxt;
      cnt_q     <= cnt_nxt;
      out_class <= class_nxt;
      out_score <= score_nxt;
      in_ready  <= (state_nxt == IDLE);
      busy      <= (state_nxt == SCAN);
      out_valid <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_fc_argmax_reader.sv
// Scoreboard bench for fc_argmax_reader: directed logit vectors, a queue of expected results and an independent monitor.
module tb_fc_argmax_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 10;
  localparam int unsigned IW = 4;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    logic [IW-1:0] cls;
    logic [DW-1:0] score;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  vec_t          in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] out_class;
  logic [DW-1:0] out_score;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;

  logic [DW-1:0] d1_in_data = '0;
  logic          d1_in_valid = 1'b0;
  logic          d1_in_ready;
  logic [0:0]    d1_out_class;
  logic [DW-1:0] d1_out_score;
  logic          d1_out_valid;
  logic          d1_busy;

  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   vrise = 0;
  exp_t q[$];

  fc_argmax_reader #(.DATA_WIDTH(DW), .OUTPUT_NODES(N), .IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_class(out_class), .out_score(out_score), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  fc_argmax_reader #(.DATA_WIDTH(DW), .OUTPUT_NODES(1), .IDX_WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(d1_in_data), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .out_class(d1_out_class), .out_score(d1_out_score), .out_valid(d1_out_valid),
    .out_ready(1'b1), .busy(d1_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops one expectation per rising out_valid, checks hold stability and one-cycle pulse
  exp_t          e;
  logic          seen = 1'b0;
  logic          hs_prev = 1'b0;
  logic [IW-1:0] held_c;
  logic [DW-1:0] held_s;

  always @(negedge clk) begin
    if (reset) begin
      seen    = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("valid_one_cycle", 32'(out_valid), 32'd0);
      hs_prev = 1'b0;
      if (out_valid) begin
        if (!seen) begin
          vrise++;
          if (q.size() == 0) begin
            total++;
            $display("FAIL unexpected_out_valid: got class %0d score 0x%0h expected no result", out_class, out_score);
          end else begin
            e = q.pop_front();
            chk("out_class", 32'(out_class), 32'(e.cls));
            chk("out_score", 32'(out_score), 32'(e.score));
            chk("latency", 32'(cyc - e.acc), 32'(N - 1));
          end
          held_c = out_class;
          held_s = out_score;
          seen   = 1'b1;
        end else begin
          chk("hold_class", 32'(out_class), 32'(held_c));
          chk("hold_score", 32'(out_score), 32'(held_s));
        end
        if (out_ready) begin
          seen    = 1'b0;
          hs_prev = 1'b1;
        end
      end
    end
  end

  // Present a vector from posedge+1 and wait for in_ready; the accept edge is the next posedge
  task automatic send(input vec_t v, input logic [IW-1:0] c, input logic [DW-1:0] s);
    int n = 0;
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end else begin
      q.push_back('{cls: c, score: s, acc: cyc + 1});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(q.size() == 0 && !out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  vec_t v;
  int   n;
  int   vr0;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_out_score", 32'(out_score), 32'd0);
    @(posedge clk);
    #1;

    v = '0; v[0] = 16'h0100; v[1] = 16'h0200; v[2] = 16'h7FFF;
    send(v, 4'd2, 16'h7FFF);
    @(negedge clk);
    chk("busy_in_scan", 32'(busy), 32'd1);
    chk("in_ready_in_scan", 32'(in_ready), 32'd0);
    drain();

    v = '{default: 16'h8000}; v[0] = 16'hFFF0; v[1] = 16'hFF00; v[2] = 16'hFFFF;
    send(v, 4'd2, 16'hFFFF);
    drain();

    v = '{default: 16'h0050};
    send(v, 4'd0, 16'h0050);
    drain();

    v = '0; v[3] = 16'h0400; v[7] = 16'h0400;
    send(v, 4'd3, 16'h0400);
    drain();

    // Back-pressure with a second vector waiting upstream
    out_ready = 1'b0;
    v = '0; v[4] = 16'h0500;
    send(v, 4'd4, 16'h0500);
    v = '{default: 16'h0100}; v[9] = 16'h0123;
    in_data  = v;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (20) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(v, 4'd9, 16'h0123);
    drain();

    // Asynchronous reset with the scan counter at 5
    v = '0; v[6] = 16'h0777;
    send(v, 4'd6, 16'h0777);
    repeat (4) @(posedge clk);
    #2 chk("busy_before_reset", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    q.delete();
    vr0 = vrise;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_class", 32'(out_class), 32'd0);
    chk("arst_out_score", 32'(out_score), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("no_valid_after_reset", 32'(vrise), 32'(vr0));
    @(posedge clk);
    #1;
    v = '{default: 16'h8000}; v[5] = 16'h8001;
    send(v, 4'd5, 16'h8001);
    drain();

    // Single-node instance: DONE on the accept edge
    d1_in_data  = 16'h8001;
    d1_in_valid = 1'b1;
    @(negedge clk);
    chk("n1_in_ready", 32'(d1_in_ready), 32'd1);
    @(posedge clk);
    #1 d1_in_valid = 1'b0;
    @(negedge clk);
    chk("n1_out_valid", 32'(d1_out_valid), 32'd1);
    chk("n1_out_class", 32'(d1_out_class), 32'd0);
    chk("n1_out_score", 32'(d1_out_score), 32'h8001);
    chk("n1_busy", 32'(d1_busy), 32'd0);
    chk("n1_in_ready_done", 32'(d1_in_ready), 32'd0);
    @(negedge clk);
    chk("n1_valid_drop", 32'(d1_out_valid), 32'd0);
    chk("n1_in_ready_back", 32'(d1_in_ready), 32'd1);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fc_argmax_reader.md
Name: fc_argmax_reader

Overview:
- Consumer at the output end of the fully connected bias-add stage.
- Captures the packed OUTPUT_NODES x DATA_WIDTH logit vector (cnn_out) on a valid/ready handshake.
- Scans the vector sequentially, one element per clock, and returns the winning class index and its score on a valid/ready output handshake.
- Feeds the classification result to the top-level result register and debug interface.

Parameters:
- DATA_WIDTH, 16: width of one logit; two's complement signed fixed-point.
- OUTPUT_NODES, 10: number of logits in the packed input vector; minimum 1.
- IDX_WIDTH, 4: width of the class index; must satisfy 2^IDX_WIDTH >= OUTPUT_NODES.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_WIDTH*OUTPUT_NODES  packed logits; element i is in_data[DATA_WIDTH*i +: DATA_WIDTH].
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a vector.
- out_class  output  IDX_WIDTH  index of the maximum logit.
- out_score  output  DATA_WIDTH  value of the maximum logit.
- out_valid  output  1  out_class and out_score are valid.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  high while in SCAN.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_class=0, out_score=0, busy=0. Internal vector register and scan counter are cleared.
- Reset mid-operation: any in-flight vector or result is discarded. No out_valid is produced for it.
- States:
  - IDLE: in_ready=1, busy=0, out_valid=0.
  - SCAN: in_ready=0, busy=1, out_valid=0.
  - DONE: in_ready=0, busy=0, out_valid=1.
- Accept: at a rising edge with state=IDLE and in_valid=1:
  - Register the whole in_data vector.
  - Load running max = element 0 and running index = 0.
  - Set scan counter = 1.
  - Go to SCAN; if OUTPUT_NODES=1, go directly to DONE.
  - in_data may change after the accept edge without effect.
- SCAN: each edge compares element[counter] with running max as signed values.
  - If the element is strictly greater, it becomes the new max and counter becomes the new index.
  - Counter then increments.
  - On the edge comparing element OUTPUT_NODES-1, go to DONE.
- Tie rule: equal values never replace the running max, so the lowest index wins.
- Latency: out_valid goes high OUTPUT_NODES-1 edges after the accept edge (9 for the default).
- DONE:
  - out_class = running index; out_score = running max.
  - Both are held stable while out_valid=1 and out_ready=0.
  - At an edge with out_ready=1, go to IDLE and clear out_valid; out_class and out_score keep their last values.
  - No new vector is accepted on the same edge, because in_ready=0 in DONE. Minimum period between accepts is OUTPUT_NODES+1 cycles.
- in_valid outside IDLE is ignored; upstream holds it until in_ready. in_valid=1 together with reset is ignored.
- Arithmetic: comparison only; no saturation or overflow is possible. Index counter width is IDX_WIDTH and never exceeds OUTPUT_NODES-1.
- Implementation note: a single shared DATA_WIDTH comparator with a mux selecting element[counter] is sufficient.

Test Plan:
- Reset, then in_valid with logits [0x0100,0x0200,0x7FFF,0x0000,...,0x0000]; out_ready=1.
  -> out_valid rises 9 edges after accept, out_class=2, out_score=0x7FFF, out_valid lasts one cycle.
- All-negative vector [0xFFF0,0xFF00,0xFFFF,0x8000,...] (0xFFFF at index 2, all others more negative).
  -> out_class=2, out_score=0xFFFF, confirming the signed compare.
- Ties: all ten logits = 0x0050.
  -> out_class=0. A separate vector with 0x0400 at indices 3 and 7, all others 0 -> out_class=3.
- Back-pressure: out_ready=0 for 20 cycles after out_valid, with in_valid held high carrying a second vector (max 0x0123 at index 9).
  -> First result is stable, in_ready=0, and the second vector is not taken.
  -> After out_ready=1, the second vector is accepted on the next IDLE edge and gives out_class=9, out_score=0x0123.
- Reset asserted asynchronously mid-SCAN (counter=5).
  -> All outputs return to their reset values immediately, no out_valid follows, and the next vector processes normally.
- Parameter check with OUTPUT_NODES=1, IDX_WIDTH=1.
  -> DONE is entered on the accept edge, out_valid rises the next cycle, and out_class=0.
